// File: rtl/control_pkg.sv
// Shared opcode map, FSM state encoding, ALU codes and strobe bundle for the hardwired
// control sequencer and its strobe decoder.
package control_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHL  = 5'd7;
  localparam logic [4:0] OP_SHR  = 5'd8;
  localparam logic [4:0] OP_ADDI = 5'd9;
  localparam logic [4:0] OP_ANDI = 5'd10;
  localparam logic [4:0] OP_ORI  = 5'd11;
  localparam logic [4:0] OP_JR   = 5'd20;
  localparam logic [4:0] OP_JAL  = 5'd21;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
    ALU_SHL = 4'd4, ALU_SHR = 4'd5
  } alu_op_t;

  typedef enum logic [3:0] {
    C_NONE, C_ALU_REG, C_ALU_IMM, C_LDI, C_LD, C_ST, C_JR, C_JAL, C_HALT
  } op_class_t;

  typedef struct packed {
    logic pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in, zlow_out, c_out;
    logic gra, grb, grc, r_in, r_out, ba_out, r15_in, read, write;
  } strobes_t;

  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR: return C_ALU_REG;
      OP_ADDI, OP_ANDI, OP_ORI:                     return C_ALU_IMM;
      OP_LDI:  return C_LDI;
      OP_LD:   return C_LD;
      OP_ST:   return C_ST;
      OP_JR:   return C_JR;
      OP_JAL:  return C_JAL;
      OP_HALT: return C_HALT;
      default: return C_NONE;
    endcase
  endfunction

  function automatic alu_op_t alu_of(input logic [4:0] op);
    case (op)
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI:   return ALU_OR;
      OP_SHL:          return ALU_SHL;
      OP_SHR:          return ALU_SHR;
      default:         return ALU_ADD;
    endcase
  endfunction

  // Final micro-step of each instruction class; the step after it is an instruction boundary.
  function automatic logic is_last(input state_t s, input op_class_t c);
    case (c)
      C_JAL:                         return s == S_T4;
      C_ALU_REG, C_ALU_IMM, C_LDI:   return s == S_T5;
      C_LD, C_ST:                    return s == S_T7;
      default:                       return s == S_T3;
    endcase
  endfunction

endpackage

// File: rtl/control_strobe_decode.sv
// Combinational map from FSM state (and opcode once decoded) to the strobe bundle and ALU code.
module control_strobe_decode
  import control_pkg::*;
(
  input  state_t         state,
  input  logic [4:0]     opcode,
  output strobes_t       strobes,
  output logic [3:0]     alu_op
);

  op_class_t cls;

  always_comb begin
    strobes = '0;
    alu_op  = ALU_ADD;
    cls     = op_class(opcode);
    case (state)
      S_T0: begin strobes.pc_out = 1'b1; strobes.mar_in = 1'b1; strobes.inc_pc = 1'b1; strobes.z_in = 1'b1; end
      S_T1: begin strobes.zlow_out = 1'b1; strobes.pc_in = 1'b1; strobes.read = 1'b1; strobes.mdr_in = 1'b1; end
      S_T2: begin strobes.mdr_out = 1'b1; strobes.ir_in = 1'b1; end
      S_T3: begin
        case (cls)
          C_ALU_REG, C_ALU_IMM: begin strobes.grb = 1'b1; strobes.r_out = 1'b1; strobes.y_in = 1'b1; end
          C_LDI, C_LD, C_ST:    begin strobes.grb = 1'b1; strobes.ba_out = 1'b1; strobes.y_in = 1'b1; end
          C_JR:  begin strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.pc_in = 1'b1; end
          C_JAL: begin strobes.pc_out = 1'b1; strobes.r15_in = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_ALU_REG: begin strobes.grc = 1'b1; strobes.r_out = 1'b1; strobes.z_in = 1'b1; alu_op = alu_of(opcode); end
          C_ALU_IMM: begin strobes.c_out = 1'b1; strobes.z_in = 1'b1; alu_op = alu_of(opcode); end
          C_LDI, C_LD, C_ST: begin strobes.c_out = 1'b1; strobes.z_in = 1'b1; end
          C_JAL: begin strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.pc_in = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_ALU_REG, C_ALU_IMM, C_LDI: begin strobes.zlow_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1; end
          C_LD, C_ST: begin strobes.zlow_out = 1'b1; strobes.mar_in = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        if (cls == C_LD) begin strobes.read = 1'b1; strobes.mdr_in = 1'b1; end
        else if (cls == C_ST) begin strobes.gra = 1'b1; strobes.r_out = 1'b1; strobes.mdr_in = 1'b1; end
      end
      S_T7: begin
        if (cls == C_LD) begin strobes.mdr_out = 1'b1; strobes.gra = 1'b1; strobes.r_in = 1'b1; end
        else if (cls == C_ST) strobes.write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch/decode/execute step register, memory wait counter
// with timeout, sticky fault flag. Strobes are decoded from the registered step.
module control_sequencer
  import control_pkg::*;
#(
  parameter int OPW         = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic           stop,
  input  logic [OPW-1:0] opcode,
  input  logic           con_ff,
  input  logic           mem_ready,
  output logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout,
  output logic Gra, Grb, Grc, Rin, Rout, BAout, R15in,
  output logic           Read,
  output logic           Write,
  output logic [3:0]     alu_op,
  output logic           running,
  output logic           fault
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MEM_TIMEOUT - 1);

  state_t          state_reg;
  state_t          done_next;
  logic [CW-1:0]   wait_cnt_reg;
  logic            fault_reg;
  logic            waiting;
  op_class_t       cls;
  strobes_t        strobes;
  logic            unused_con_ff;

  assign unused_con_ff = con_ff;

  always_comb begin
    cls     = op_class(opcode);
    waiting = (state_reg == S_T1) ||
              (state_reg == S_T6 && cls == C_LD) ||
              (state_reg == S_T7 && cls == C_ST);
    if (state_reg == S_T3 && cls == C_HALT)
      done_next = S_HALT;
    else if (is_last(state_reg, cls))
      done_next = stop ? S_HALT : S_T0;
    else
      done_next = state_t'(state_reg + 4'd1);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= '0;
      fault_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_HALT: if (start && !stop) state_reg <= S_T0;
        S_FAULT: ;
        default: begin
          // A ready on the limit cycle still completes the transfer.
          if (!waiting) begin
            state_reg <= done_next;
          end else if (mem_ready) begin
            state_reg    <= done_next;
            wait_cnt_reg <= '0;
          end else if (wait_cnt_reg == WAIT_LIMIT) begin
            state_reg    <= S_FAULT;
            fault_reg    <= 1'b1;
            wait_cnt_reg <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  control_strobe_decode u_decode (
    .state   (state_reg),
    .opcode  (opcode),
    .strobes (strobes),
    .alu_op  (alu_op)
  );

  assign {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout,
          Gra, Grb, Grc, Rin, Rout, BAout, R15in, Read, Write} = strobes;
  assign running = (state_reg >= S_T0) && (state_reg <= S_T7);
  assign fault   = fault_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: steps instructions cycle by cycle and checks strobes.
module tb_control_sequencer;

  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, stop = 1'b0, con_ff = 1'b0, mem_ready = 1'b1;
  logic [4:0] opcode = 5'd0;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, R15in, Read, Write, running, fault;
  logic [3:0] alu_op;
  logic [19:0] sv;
  int compared = 0, mismatched = 0;

  localparam logic [19:0] PCOUT = 20'd1 << 19, PCIN = 20'd1 << 18, INCPC = 20'd1 << 17,
    MARIN = 20'd1 << 16, MDRIN = 20'd1 << 15, MDROUT = 20'd1 << 14, IRIN = 20'd1 << 13,
    YIN = 20'd1 << 12, ZIN = 20'd1 << 11, ZLOWOUT = 20'd1 << 10, COUT = 20'd1 << 9,
    GRA = 20'd1 << 8, GRB = 20'd1 << 7, GRC = 20'd1 << 6, RIN = 20'd1 << 5, ROUT = 20'd1 << 4,
    BAOUT = 20'd1 << 3, R15IN = 20'd1 << 2, READ = 20'd1 << 1, WRITE = 20'd1;
  localparam logic [19:0] F_T0 = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [19:0] F_T1 = ZLOWOUT | PCIN | READ | MDRIN;
  localparam logic [19:0] F_T2 = MDROUT | IRIN;

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .opcode(opcode),
    .con_ff(con_ff), .mem_ready(mem_ready),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .R15in(R15in),
    .Read(Read), .Write(Write), .alu_op(alu_op), .running(running), .fault(fault)
  );

  assign sv = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout,
               Gra, Grb, Grc, Rin, Rout, BAout, R15in, Read, Write};

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
    $display("check %-14s observed %05h expected %05h", tag, obs, exp);
  endtask

  // Checks strobe vector, running flag and ALU code in one go.
  task automatic chk_step(input string tag, input logic [19:0] exp_sv, input logic exp_run,
                          input logic [3:0] exp_alu);
    chk({tag, ".strobes"}, sv, exp_sv);
    chk({tag, ".running"}, {19'd0, running}, {19'd0, exp_run});
    chk({tag, ".alu_op"}, {16'd0, alu_op}, {16'd0, exp_alu});
  endtask

  task automatic fetch(input string tag);
    step(); chk_step({tag, "_t1"}, F_T1, 1'b1, 4'd0);
    step(); chk_step({tag, "_t2"}, F_T2, 1'b1, 4'd0);
  endtask

  initial begin
    @(negedge clock);
    step(); step();
    chk_step("reset", 20'd0, 1'b0, 4'd0);
    chk("reset.fault", {19'd0, fault}, 20'd0);

    // add r,r,r through T0..T5 and back to T0
    reset_n = 1'b1; start = 1'b1; opcode = 5'd3;
    step(); chk_step("add_t0", F_T0, 1'b1, 4'd0);
    fetch("add");
    step(); chk_step("add_t3", GRB | ROUT | YIN, 1'b1, 4'd0);
    step(); chk_step("add_t4", GRC | ROUT | ZIN, 1'b1, 4'd0);
    step(); chk_step("add_t5", ZLOWOUT | GRA | RIN, 1'b1, 4'd0);
    step(); chk_step("add_next_t0", F_T0, 1'b1, 4'd0);

    // sub: ALU code follows opcode in T4
    opcode = 5'd4;
    fetch("sub");
    step(); chk_step("sub_t3", GRB | ROUT | YIN, 1'b1, 4'd0);
    step(); chk_step("sub_t4", GRC | ROUT | ZIN, 1'b1, 4'd1);
    step(); chk_step("sub_t5", ZLOWOUT | GRA | RIN, 1'b1, 4'd0);
    step(); chk_step("sub_next_t0", F_T0, 1'b1, 4'd0);

    // fetch wait: three not-ready cycles, Read held four cycles, T2 on fifth edge
    opcode = 5'd21; mem_ready = 1'b0;
    step(); chk_step("wait_c1", F_T1, 1'b1, 4'd0);
    step(); chk_step("wait_c2", F_T1, 1'b1, 4'd0);
    step(); chk_step("wait_c3", F_T1, 1'b1, 4'd0);
    step(); chk_step("wait_c4", F_T1, 1'b1, 4'd0);
    mem_ready = 1'b1;
    step(); chk_step("wait_t2", F_T2, 1'b1, 4'd0);
    step(); chk_step("jal_t3", PCOUT | R15IN, 1'b1, 4'd0);
    step(); chk_step("jal_t4", GRA | ROUT | PCIN, 1'b1, 4'd0);
    step(); chk_step("jal_next_t0", F_T0, 1'b1, 4'd0);

    // ready arriving on the limit cycle still advances
    opcode = 5'd26; mem_ready = 1'b0;
    step();
    for (int i = 0; i < 254; i++) step();
    chk_step("limit_wait", F_T1, 1'b1, 4'd0);
    mem_ready = 1'b1;
    step(); chk_step("limit_ready_t2", F_T2, 1'b1, 4'd0);
    chk("limit.fault", {19'd0, fault}, 20'd0);
    step(); chk_step("nop_t3", 20'd0, 1'b1, 4'd0);
    step(); chk_step("nop_next_t0", F_T0, 1'b1, 4'd0);

    // addi with stop raised at T4: finishes T5, then HALT; start&stop stays halted
    opcode = 5'd9;
    fetch("addi");
    step(); chk_step("addi_t3", GRB | ROUT | YIN, 1'b1, 4'd0);
    step(); chk_step("addi_t4", COUT | ZIN, 1'b1, 4'd0);
    stop = 1'b1;
    step(); chk_step("addi_t5", ZLOWOUT | GRA | RIN, 1'b1, 4'd0);
    step(); chk_step("halt_entry", 20'd0, 1'b0, 4'd0);
    step(); chk_step("halt_stay", 20'd0, 1'b0, 4'd0);
    stop = 1'b0;
    step(); chk_step("restart_t0", F_T0, 1'b1, 4'd0);

    // ld with T6 never ready -> FAULT after MEM_TIMEOUT waiting cycles
    opcode = 5'd0;
    fetch("ld");
    step(); chk_step("ld_t3", GRB | BAOUT | YIN, 1'b1, 4'd0);
    step(); chk_step("ld_t4", COUT | ZIN, 1'b1, 4'd0);
    step(); chk_step("ld_t5", ZLOWOUT | MARIN, 1'b1, 4'd0);
    mem_ready = 1'b0;
    step(); chk_step("ld_t6", READ | MDRIN, 1'b1, 4'd0);
    for (int i = 0; i < 254; i++) step();
    chk_step("ld_t6_last", READ | MDRIN, 1'b1, 4'd0);
    chk("ld_prefault", {19'd0, fault}, 20'd0);
    step(); chk_step("fault_entry", 20'd0, 1'b0, 4'd0);
    chk("fault_flag", {19'd0, fault}, 20'd1);
    step(); chk_step("fault_stay", 20'd0, 1'b0, 4'd0);
    chk("fault_sticky", {19'd0, fault}, 20'd1);

    // reset clears fault; st then reset during the T7 write wait
    reset_n = 1'b0;
    step(); chk("reset2.fault", {19'd0, fault}, 20'd0);
    reset_n = 1'b1; mem_ready = 1'b1; opcode = 5'd2;
    step(); chk_step("st_t0", F_T0, 1'b1, 4'd0);
    fetch("st");
    step(); chk_step("st_t3", GRB | BAOUT | YIN, 1'b1, 4'd0);
    step(); chk_step("st_t4", COUT | ZIN, 1'b1, 4'd0);
    step(); chk_step("st_t5", ZLOWOUT | MARIN, 1'b1, 4'd0);
    step(); chk_step("st_t6", GRA | ROUT | MDRIN, 1'b1, 4'd0);
    mem_ready = 1'b0;
    step(); chk_step("st_t7", WRITE, 1'b1, 4'd0);
    step(); chk_step("st_t7_wait", WRITE, 1'b1, 4'd0);
    reset_n = 1'b0;
    step(); chk_step("st_reset", 20'd0, 1'b0, 4'd0);
    chk("st_reset.fault", {19'd0, fault}, 20'd0);

    // halt opcode ends in HALT
    reset_n = 1'b1; mem_ready = 1'b1; opcode = 5'd27;
    step(); chk_step("hlt_t0", F_T0, 1'b1, 4'd0);
    fetch("hlt");
    start = 1'b0;
    step(); chk_step("hlt_t3", 20'd0, 1'b1, 4'd0);
    step(); chk_step("hlt_halted", 20'd0, 1'b0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
